// File: rtl/riscv_pkg.sv
// Shared RISC-V constants for the fetch slice.
//   XLEN      : default address/data width
//   RESET_PC  : default first fetch address after reset
//   opcode_t  : base-ISA major opcodes as seen in instr[6:0]
//   wordAlign : clears the two byte-offset bits of an address
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_FENCE  = 7'b0001111,
        OP_IMM    = 7'b0010011,
        OP_AUIPC  = 7'b0010111,
        OP_STORE  = 7'b0100011,
        OP_R      = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111,
        OP_SYSTEM = 7'b1110011
    } opcode_t;

    function automatic logic [XLEN-1:0] wordAlign(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and memory (slave).
//   imemReqValid / imemReqReady : request handshake
//   imemAddr                    : word-aligned request address
//   imemRspValid / imemRspData  : in-order response, no backpressure
interface instr_fetch_unit_if #(
    parameter int XLEN = riscv_pkg::XLEN
);
    logic            imemReqValid;
    logic            imemReqReady;
    logic [XLEN-1:0] imemAddr;
    logic            imemRspValid;
    logic [31:0]     imemRspData;

    modport master (
        output imemReqValid, imemAddr,
        input  imemReqReady, imemRspValid, imemRspData
    );

    modport slave (
        input  imemReqValid, imemAddr,
        output imemReqReady, imemRspValid, imemRspData
    );
endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// fetch_fifo: synchronous FIFO of {pc, instr} pairs feeding decode.
//   pushValid/pushPc/pushInstr : write port (push on a full FIFO only with a pop)
//   popReady                   : consume head when headValid
//   headValid/headPc/headInstr : head entry, combinational from storage
//   flush                      : empties the FIFO at the next edge
//   count                      : current occupancy
module fetch_fifo #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             pushValid,
    input  logic [XLEN-1:0]  pushPc,
    input  logic [31:0]      pushInstr,
    input  logic             popReady,
    output logic             headValid,
    output logic [XLEN-1:0]  headPc,
    output logic [31:0]      headInstr,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } entry_t;

    entry_t           storage [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             full;
    logic             doPush;
    logic             doPop;

    // Pointer increment that also works for non-power-of-two depths.
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full      = (count == CNT_W'(DEPTH));
    assign headValid = (count != '0);
    assign doPop     = headValid && popReady;
    assign doPush    = pushValid && (!full || doPop);
    assign headPc    = storage[rdPtr].pc;
    assign headInstr = storage[rdPtr].instr;

    // NOTE: state is updated with <= so every register samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= bump(wrPtr);
            if (doPop)  rdPtr <= bump(rdPtr);
            count <= count + CNT_W'(doPush) - CNT_W'(doPop);
        end
    end

    // NOTE: storage is deliberately not reset; count gates every read of it.
    always_ff @(posedge clk) begin
        if (doPush && !flush) storage[wrPtr] <= '{pc: pushPc, instr: pushInstr};
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, issues word fetches over imem, buffers the
// in-order responses and presents them to decode. A pcSrc redirect flushes
// buffered entries and drops every response still owed to the old stream.
//   clk, rst                     : clock, synchronous active-high reset
//   imem (master)                : instruction-memory request/response bus
//   instrValid/instrReady        : decode handshake for the FIFO head
//   instr, pcOut                 : head instruction word and its address
//   op, funct3, funct7           : decode fields of instr
//   pcSrc, pcTarget              : one-cycle redirect from execute
//   addrMisaligned               : pulse when a redirect target is not word aligned
module instr_fetch_unit #(
    parameter int              XLEN       = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = riscv_pkg::RESET_PC,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    instr_fetch_unit_if.master        imem,
    output logic                      instrValid,
    input  logic                      instrReady,
    output logic [31:0]               instr,
    output logic [XLEN-1:0]           pcOut,
    output logic [6:0]                op,
    output logic [2:0]                funct3,
    output logic [6:0]                funct7,
    input  logic                      pcSrc,
    input  logic [XLEN-1:0]           pcTarget,
    output logic                      addrMisaligned
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [XLEN-1:0]  fetchPc;     // next address to raise a request for
    logic [XLEN-1:0]  rspPc;       // address of the next response kept for decode
    logic [XLEN-1:0]  heldAddr;    // address of a request waiting for imemReqReady
    logic             reqHeld;
    logic [CNT_W-1:0] outstanding; // accepted requests not yet answered
    logic [CNT_W-1:0] dropCnt;     // stale responses still to be discarded
    logic [CNT_W-1:0] fifoCount;

    logic             canIssue;
    logic             reqFire;
    logic             rspLive;
    logic             rspDrop;
    logic             rspPush;
    logic             popFire;
    logic [CNT_W:0]   inFlight;
    logic [XLEN-1:0]  targetAligned;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        inFlight      = {1'b0, fifoCount} + {1'b0, outstanding};
        canIssue      = inFlight < (CNT_W + 1)'(FIFO_DEPTH);
        reqFire       = imem.imemReqValid && imem.imemReqReady;
        // Replies arriving with nothing outstanding belong to a pre-reset stream.
        rspLive       = imem.imemRspValid && (outstanding != '0);
        // A reply in the redirect cycle still belongs to the old stream.
        rspDrop       = rspLive && ((dropCnt != '0) || pcSrc);
        rspPush       = rspLive && !rspDrop;
        popFire       = instrValid && instrReady;
        targetAligned = riscv_pkg::wordAlign(pcTarget);
    end

    assign imem.imemReqValid = !rst && (reqHeld || canIssue);
    assign imem.imemAddr     = reqHeld ? heldAddr : fetchPc;
    assign addrMisaligned    = !rst && pcSrc && (pcTarget[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetchPc     <= RESET_PC;
            rspPc       <= RESET_PC;
            heldAddr    <= RESET_PC;
            reqHeld     <= 1'b0;
            outstanding <= '0;
            dropCnt     <= '0;
        end else begin
            reqHeld <= imem.imemReqValid && !imem.imemReqReady;
            if (!reqHeld) heldAddr <= fetchPc;

            if (pcSrc) begin
                fetchPc <= targetAligned;
                rspPc   <= targetAligned;
                // Everything in flight after this edge, plus a request raised
                // now (accepted or held), answers for the old stream.
                dropCnt <= outstanding - CNT_W'(rspLive) + CNT_W'(imem.imemReqValid);
            end else begin
                // fetchPc moves on as soon as a request is raised; a held
                // request keeps its own copy of the address in heldAddr.
                if (imem.imemReqValid && !reqHeld) fetchPc <= fetchPc + XLEN'(4);
                if (rspPush) rspPc <= rspPc + XLEN'(4);
                if (rspDrop) dropCnt <= dropCnt - CNT_W'(1);
            end

            outstanding <= outstanding + CNT_W'(reqFire) - CNT_W'(rspLive);
        end
    end

    fetch_fifo #(
        .XLEN  (XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (pcSrc),
        .pushValid (rspPush),
        .pushPc    (rspPc),
        .pushInstr (imem.imemRspData),
        .popReady  (instrReady),
        .headValid (instrValid),
        .headPc    (pcOut),
        .headInstr (instr),
        .count     (fifoCount)
    );

    assign op     = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a one-cycle instruction memory whose
// replies can be held back, plus a linear sequence of fetch scenarios.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        instrValid;
    logic        instrReady;
    logic [31:0] instr;
    logic [31:0] pcOut;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        pcSrc;
    logic [31:0] pcTarget;
    logic        addrMisaligned;

    int nChecks = 0;
    int nPass   = 0;
    int nFail   = 0;

    logic [31:0] memQ[$];    // accepted addresses awaiting a reply
    logic [31:0] reqLog[$];  // every accepted request address since last reset
    bit          memHold;    // keep replies queued while set

    instr_fetch_unit_if #(.XLEN(32)) bus ();

    instr_fetch_unit #(
        .XLEN       (32),
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem           (bus),
        .instrValid     (instrValid),
        .instrReady     (instrReady),
        .instr          (instr),
        .pcOut          (pcOut),
        .op             (op),
        .funct3         (funct3),
        .funct7         (funct7),
        .pcSrc          (pcSrc),
        .pcTarget       (pcTarget),
        .addrMisaligned (addrMisaligned)
    );

    always #5 clk = ~clk;

    // Memory contents: an R-type word whose funct7/funct3 encode the address.
    function automatic logic [31:0] instrOf(input logic [31:0] a);
        return {a[8:2], 10'h000, a[4:2], 5'h00, 7'b0110011};
    endfunction

    function automatic logic [31:0] logAt(input int i);
        if (i < reqLog.size()) return reqLog[i];
        return 'x;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) nPass++;
        else begin
            nFail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One clock: sample the request handshake, clock, then drive the reply
    // for the previous cycle's handshake (one-cycle memory).
    task automatic tick();
        logic        hs;
        logic [31:0] a;
        #1;
        hs = bus.imemReqValid && bus.imemReqReady;
        a  = bus.imemAddr;
        @(posedge clk);
        if (hs) begin
            memQ.push_back(a);
            reqLog.push_back(a);
        end
        @(negedge clk);
        bus.imemRspValid = 1'b0;
        bus.imemRspData  = '0;
        if (!memHold && memQ.size() > 0) begin
            bus.imemRspValid = 1'b1;
            bus.imemRspData  = instrOf(memQ.pop_front());
        end
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        reqLog.delete();
        #1;
    endtask

    // Wait (bounded) for the next decode entry, check it, and consume it.
    task automatic expectInstr(input logic [31:0] pc);
        logic [31:0] a;
        int n;
        a = pc;
        n = 0;
        while (!instrValid && n < 20) begin
            tick();
            n++;
        end
        check($sformatf("instrValid@%h", pc), instrValid, 1);
        if (instrValid) begin
            check($sformatf("pcOut@%h", pc), pcOut, pc);
            check($sformatf("instr@%h", pc), instr, instrOf(pc));
            check($sformatf("op@%h", pc), op, 32'(riscv_pkg::OP_R));
            check($sformatf("funct3@%h", pc), funct3, a[4:2]);
            check($sformatf("funct7@%h", pc), funct7, a[8:2]);
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst              = 1'b1;
        bus.imemReqReady = 1'b1;
        bus.imemRspValid = 1'b0;
        bus.imemRspData  = '0;
        instrReady       = 1'b1;
        pcSrc            = 1'b0;
        pcTarget         = '0;
        memHold          = 1'b0;

        // T1: reset state, then in-order stream from RESET_PC.
        tick();
        tick();
        check("rst reqValid", bus.imemReqValid, 0);
        check("rst instrValid", instrValid, 0);
        check("rst misaligned", addrMisaligned, 0);
        rst = 1'b0;
        reqLog.delete();
        #1;
        check("t1 first reqValid", bus.imemReqValid, 1);
        check("t1 first addr", bus.imemAddr, 32'h0);
        expectInstr(32'h0);
        expectInstr(32'h4);
        expectInstr(32'h8);
        check("t1 req0", logAt(0), 32'h0);
        check("t1 req1", logAt(1), 32'h4);
        check("t1 req2", logAt(2), 32'h8);

        // T2: decode stalled, issue stops at FIFO_DEPTH in flight.
        instrReady = 1'b0;
        doReset();
        repeat (8) tick();
        check("t2 nreq", reqLog.size(), 2);
        check("t2 req0", logAt(0), 32'h0);
        check("t2 req1", logAt(1), 32'h4);
        check("t2 reqValid low", bus.imemReqValid, 0);
        check("t2 head valid", instrValid, 1);
        check("t2 head pc", pcOut, 32'h0);
        instrReady = 1'b1;
        #1;
        expectInstr(32'h0);
        expectInstr(32'h4);
        expectInstr(32'h8);
        check("t2 req2", logAt(2), 32'h8);

        // T3: redirect with one buffered entry and one reply outstanding.
        instrReady = 1'b0;
        doReset();
        tick();
        memHold = 1'b1;
        tick();
        check("t3 buffered", instrValid, 1);
        check("t3 buffered pc", pcOut, 32'h0);
        check("t3 no issue", bus.imemReqValid, 0);
        pcSrc    = 1'b1;
        pcTarget = 32'h100;
        #1;
        check("t3 aligned no pulse", addrMisaligned, 0);
        memHold = 1'b0;
        tick();
        pcSrc = 1'b0;
        check("t3 flushed", instrValid, 0);
        check("t3 new reqValid", bus.imemReqValid, 1);
        check("t3 new addr", bus.imemAddr, 32'h100);
        instrReady = 1'b1;
        #1;
        expectInstr(32'h100);
        expectInstr(32'h104);

        // T4: misaligned redirect target.
        pcSrc    = 1'b1;
        pcTarget = 32'h102;
        #1;
        check("t4 pulse", addrMisaligned, 1);
        tick();
        pcSrc = 1'b0;
        #1;
        check("t4 pulse ends", addrMisaligned, 0);
        expectInstr(32'h100);
        expectInstr(32'h104);

        // T5: request held three cycles across a redirect.
        bus.imemReqReady = 1'b0;
        doReset();
        check("t5 held valid", bus.imemReqValid, 1);
        check("t5 held addr c0", bus.imemAddr, 32'h0);
        tick();
        check("t5 held addr c1", bus.imemAddr, 32'h0);
        pcSrc    = 1'b1;
        pcTarget = 32'h100;
        tick();
        pcSrc = 1'b0;
        check("t5 valid after redirect", bus.imemReqValid, 1);
        check("t5 held addr c2", bus.imemAddr, 32'h0);
        tick();
        bus.imemReqReady = 1'b1;
        #1;
        check("t5 accept addr", bus.imemAddr, 32'h0);
        tick();
        check("t5 new reqValid", bus.imemReqValid, 1);
        check("t5 new addr", bus.imemAddr, 32'h100);
        expectInstr(32'h100);
        check("t5 req0", logAt(0), 32'h0);
        check("t5 req1", logAt(1), 32'h100);

        // T6: reset with two requests outstanding, stray replies afterwards.
        instrReady = 1'b0;
        doReset();
        memHold = 1'b1;
        tick();
        tick();
        check("t6 outstanding reqs", reqLog.size(), 2);
        rst = 1'b1;
        tick();
        rst              = 1'b0;
        bus.imemReqReady = 1'b0;
        memHold          = 1'b0;
        #1;
        check("t6 restart valid", bus.imemReqValid, 1);
        check("t6 restart addr", bus.imemAddr, 32'h0);
        tick();
        tick();
        tick();
        check("t6 strays ignored", instrValid, 0);
        bus.imemReqReady = 1'b1;
        instrReady       = 1'b1;
        #1;
        expectInstr(32'h0);
        expectInstr(32'h4);

        // T7: fetch address wraps past the top of the address space.
        pcSrc    = 1'b1;
        pcTarget = 32'hFFFF_FFF8;
        tick();
        pcSrc = 1'b0;
        expectInstr(32'hFFFF_FFF8);
        expectInstr(32'hFFFF_FFFC);
        expectInstr(32'h0000_0000);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
